idct_block_sched: RTL and testbench
===================================

# idct_block_sched

Controller that sequences the 8x8 IDCT core over a continuous stream of coefficient blocks. It accepts 16-bit coefficients in raster order into a ping-pong pair of 64-entry banks. It drives the core's reset/start/done handshake for each block and captures the 64 result pixels into an output buffer. It then streams the pixels out in raster order. It sits between the entropy-decode/dequant stage and the pixel writer, with one IDCT core instance as its shared resource.

## Interface
- TMO_CYCLES, default 2048: core cycles allowed in C_WAIT before a block is abandoned (12-bit counter range; legal 1..4095).
- sys_clk  in  1  clock, rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset for the whole block.
- s_coef_valid  in  1  coefficient beat valid.
- s_coef_ready  out  1  coefficient beat ready; equals !bank_full[wr_bank].
- s_coef_data  in  16  signed coefficient x[r][c], beat index 8r+c.
- s_coef_last  in  1  marks beat 63 of a block.
- m_pix_valid  out  1  pixel beat valid.
- m_pix_ready  in  1  pixel beat ready.
- m_pix_data  out  8  pixel[r][c], beat index 8r+c; 0 when m_pix_valid=0.
- m_pix_last  out  1  high with beat 63.
- core_rst  out  1  synchronous active-high reset to the core.
- core_start  out  1  one-cycle start pulse to the core.
- core_done  in  1  core done level.
- core_coef  out  1024  read bank; x[r][c] at bits [16*(8r+c)+:16].
- core_pix  in  512  core pixels; pixel[r][c] at bits [8*(8r+c)+:8].
- busy  out  1  any bank full, out buffer full, or core FSM not in C_IDLE.
- err_len  out  1  sticky: s_coef_last disagrees with beat index.
- err_tmo  out  1  sticky: core timeout occurred.
- blk_count  out  16  blocks fully delivered on m_pix; wraps at 65535 to 0.

## Operation
- Input side:
  - wr_bank and wr_idx (0..63) select the write target. A beat is accepted when s_coef_valid && s_coef_ready.
  - The accepted beat writes bank[wr_bank][wr_idx] and increments wr_idx.
  - At wr_idx=63: set bank_full[wr_bank], toggle wr_bank, clear wr_idx.
  - Block framing is by count only. err_len sets if last=1 at idx≠63 or last=0 at idx=63; the block is still processed.
- Core FSM (Moore outputs), with rd_bank selecting core_coef:
  - C_IDLE: core_rst=1. Go to C_RST when bank_full[rd_bank].
  - C_RST: core_rst=1. Go to C_START.
  - C_START: core_start=1 for exactly one cycle. Clear the timeout counter. Go to C_WAIT.
  - C_WAIT: the counter increments each cycle.
    - If core_done=1, go to C_CAPT.
    - Otherwise, if counter reaches TMO_CYCLES, set err_tmo, clear bank_full[rd_bank], toggle rd_bank, and go to C_IDLE. No pixels are output for that block.
  - C_CAPT: if !out_full, latch core_pix into the out buffer, set out_full, clear bank_full[rd_bank], toggle rd_bank, and go to C_IDLE. Otherwise stay.
- The read bank is held unchanged from C_RST until release. Writes never target the read bank.
- Output side:
  - m_pix_valid=out_full. m_pix_data=outbuf[rd_idx].
  - A beat transfers when valid && ready. At rd_idx=63: clear out_full, clear rd_idx, increment blk_count.
- Reset: all state clears asynchronously.
  - Bank contents and outbuf go to 0. wr/rd bank and indices go to 0.
  - FSM goes to C_IDLE. core_rst=1, core_start=0.
  - m_pix_valid=0, m_pix_data=0, m_pix_last=0.
  - s_coef_ready=1 once reset is released.
  - err_len=0, err_tmo=0, blk_count=0, busy=0.
  - Reset mid-block discards all partial input and output.

## Timing
- Last coef accepted at cycle T: bank_full visible at T+1, C_RST at T+2, core_start high at T+3, C_WAIT from T+4.
- core_done sampled high at cycle D: C_CAPT at D+1. If out buffer is empty, m_pix_valid=1 at D+2.
- Back-to-back: up to 128 coefficients are accepted with the core idle before s_coef_ready drops. Bank release re-raises ready the cycle after C_CAPT or the timeout.
- Final pixel beat accepted in the same cycle C_CAPT is waiting: out_full clears at the next edge, and capture happens in the following cycle (one bubble). No same-cycle overwrite.
- Bank fill and bank release in the same cycle touch different banks, and both take effect.
- m_pix stalls (ready=0) hold data and valid stable and are unbounded. The core is not restarted for the next bank until capture.

## Test plan
- Single block, ramp coefficients 0..63, with last on beat 63, and m_pix_ready=1 throughout.
  - Required response: core_start pulses exactly once at T+3.
  - 64 pixels match the core's pixel_data in raster order, with m_pix_last on beat 63.
  - blk_count=1, err_len=0.
- Three back-to-back blocks with continuous valid.
  - Required response: s_coef_ready drops after beat 127 and re-rises after the first capture.
  - All 192 pixels arrive in order, and blk_count=3.
- Output backpressure: m_pix_ready=0 for 5000 cycles after the first capture, with two more blocks queued.
  - Required response: data is stable, C_CAPT waits, and s_coef_ready=0.
  - After ready is released, all blocks are delivered with none dropped.
- Framing error: last asserted on beat 10.
  - Required response: err_len=1 stays high, and the block still completes on 64 beats.
- Core model that never raises done, with TMO_CYCLES=100.
  - Required response: err_tmo=1 after 100 C_WAIT cycles, the bank is released, no pixel beats are output, and the next block proceeds.
- Assert sys_rst_n low at beat 30 of the second block, asynchronous to the clock edge.
  - Required response: m_pix_valid=0, core_rst=1, and busy=0 immediately.
  - After release, a fresh block processes correctly with blk_count starting at 0.

Source files
------------

// File: rtl/idct_block_sched_if.sv
// Signal bundle between idct_block_sched and its neighbours: the coefficient stream,
// the pixel stream, and the handshake with the shared IDCT core.
interface idct_block_sched_if;
  logic          s_coef_valid;
  logic          s_coef_ready;
  logic [15:0]   s_coef_data;
  logic          s_coef_last;

  logic          m_pix_valid;
  logic          m_pix_ready;
  logic [7:0]    m_pix_data;
  logic          m_pix_last;

  logic          core_rst;
  logic          core_start;
  logic          core_done;
  logic [1023:0] core_coef;
  logic [511:0]  core_pix;

  modport master (
    input  s_coef_valid, s_coef_data, s_coef_last, m_pix_ready, core_done, core_pix,
    output s_coef_ready, m_pix_valid, m_pix_data, m_pix_last, core_rst, core_start, core_coef
  );

  modport slave (
    output s_coef_valid, s_coef_data, s_coef_last, m_pix_ready, core_done, core_pix,
    input  s_coef_ready, m_pix_valid, m_pix_data, m_pix_last, core_rst, core_start, core_coef
  );
endinterface

// File: rtl/idct_block_sched.sv
// Sequences one 8x8 IDCT core over a coefficient stream: ping-pong input banks,
// a Moore FSM for the core handshake, and a single-block output pixel buffer.
module idct_block_sched #(
  parameter int TMO_CYCLES = 2048
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  idct_block_sched_if.master         bus,
  output logic                       busy,
  output logic                       err_len,
  output logic                       err_tmo,
  output logic [15:0]                blk_count
);
  typedef enum logic [2:0] {C_IDLE, C_RST, C_START, C_WAIT, C_CAPT} coreState_t;

  localparam logic [11:0] TMO_LAST = 12'(TMO_CYCLES - 1);

  coreState_t   r_state, w_nextState;
  logic [15:0]  r_bank [2][64];
  logic [1:0]   r_bankFull;
  logic         r_wrBank, r_rdBank;
  logic [5:0]   r_wrIdx, r_rdIdx;
  logic [11:0]  r_tmoCnt;
  logic [511:0] r_outBuf;
  logic         r_outFull;
  logic         r_errLen, r_errTmo;
  logic [15:0]  r_blkCount;

  logic w_coefAcc, w_bankFill, w_pixAcc, w_capture, w_timeout, w_release;

  assign bus.s_coef_ready = !r_bankFull[r_wrBank];
  assign w_coefAcc        = bus.s_coef_valid && bus.s_coef_ready;
  assign w_bankFill       = w_coefAcc && (r_wrIdx == 6'd63);
  assign w_pixAcc         = r_outFull && bus.m_pix_ready;
  assign w_release        = w_capture || w_timeout;

  assign bus.m_pix_valid = r_outFull;
  assign bus.m_pix_data  = r_outFull ? r_outBuf[{r_rdIdx, 3'b000} +: 8] : 8'd0;
  assign bus.m_pix_last  = r_outFull && (r_rdIdx == 6'd63);

  assign busy      = (|r_bankFull) || r_outFull || (r_state != C_IDLE);
  assign err_len   = r_errLen;
  assign err_tmo   = r_errTmo;
  assign blk_count = r_blkCount;

  always_comb begin
    bus.core_coef = '0;
    for (int i = 0; i < 64; i++) bus.core_coef[16*i +: 16] = r_bank[r_rdBank][i];
  end

  always_comb begin
    w_nextState    = r_state;
    w_capture      = 1'b0;
    w_timeout      = 1'b0;
    bus.core_rst   = 1'b0;
    bus.core_start = 1'b0;
    unique case (r_state)
      C_IDLE: begin
        bus.core_rst = 1'b1;
        if (r_bankFull[r_rdBank]) w_nextState = C_RST;
      end
      C_RST: begin
        bus.core_rst = 1'b1;
        w_nextState  = C_START;
      end
      C_START: begin
        bus.core_start = 1'b1;
        w_nextState    = C_WAIT;
      end
      C_WAIT: begin
        if (bus.core_done) begin
          w_nextState = C_CAPT;
        end else if (r_tmoCnt == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_nextState = C_IDLE;
        end
      end
      C_CAPT: begin
        if (!r_outFull) begin
          w_capture   = 1'b1;
          w_nextState = C_IDLE;
        end
      end
      default: w_nextState = C_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= C_IDLE;
      r_tmoCnt <= '0;
      r_errTmo <= 1'b0;
      r_rdBank <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == C_START) r_tmoCnt <= '0;
      else if (r_state == C_WAIT) r_tmoCnt <= r_tmoCnt + 12'd1;
      if (w_timeout) r_errTmo <= 1'b1;
      if (w_release) r_rdBank <= !r_rdBank;
    end
  end

  // Write index wraps 63->0 by itself; only the bank select needs explicit toggling.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 64; i++) r_bank[b][i] <= '0;
      r_wrBank <= 1'b0;
      r_wrIdx  <= '0;
      r_errLen <= 1'b0;
    end else if (w_coefAcc) begin
      r_bank[r_wrBank][r_wrIdx] <= bus.s_coef_data;
      r_wrIdx <= r_wrIdx + 6'd1;
      if (w_bankFill) r_wrBank <= !r_wrBank;
      if (bus.s_coef_last != (r_wrIdx == 6'd63)) r_errLen <= 1'b1;
    end
  end

  // A fill and a release in the same cycle always address different banks.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bankFull <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_bankFill && (r_wrBank == 1'(b))) r_bankFull[b] <= 1'b1;
        else if (w_release && (r_rdBank == 1'(b))) r_bankFull[b] <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_outBuf   <= '0;
      r_outFull  <= 1'b0;
      r_rdIdx    <= '0;
      r_blkCount <= '0;
    end else begin
      if (w_capture) begin
        r_outBuf  <= bus.core_pix;
        r_outFull <= 1'b1;
      end else if (w_pixAcc && (r_rdIdx == 6'd63)) begin
        r_outFull <= 1'b0;
      end
      if (w_pixAcc) begin
        r_rdIdx <= r_rdIdx + 6'd1;
        if (r_rdIdx == 6'd63) r_blkCount <= r_blkCount + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_idct_block_sched.sv
// Self-checking bench for idct_block_sched with a behavioural IDCT core stand-in
// and a queue-based model of the pixels each delivered block must produce.
module tb_idct_block_sched;
  localparam int TMO = 100;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        busy, err_len, err_tmo;
  logic [15:0] blk_count;

  idct_block_sched_if bus();

  idct_block_sched #(.TMO_CYCLES(TMO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .busy      (busy),
    .err_len   (err_len),
    .err_tmo   (err_tmo),
    .blk_count (blk_count)
  );

  always #5 sys_clk = ~sys_clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  expPix [$];
  logic [7:0]  rxPix [$];
  logic        rxLast [$];
  int          expBlk = 0;
  bit          noDone = 1'b0;
  bit          stallAll = 1'b0;
  bit          randReady = 1'b0;
  int          fixedLat = 0;
  int          startPulses = 0;

  // Stand-in transform: every output pixel mixes two distant coefficients and its own index.
  function automatic logic [511:0] pixOf(input logic [1023:0] c);
    logic [511:0] p;
    for (int i = 0; i < 64; i++)
      p[8*i +: 8] = c[16*i +: 8] ^ c[16*(63-i) + 8 +: 8] ^ 8'(i * 37);
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Core stand-in: synchronous reset, start captures the read bank, done is a level.
  initial begin
    logic          sRst, sStart;
    logic [1023:0] sCoef, heldCoef;
    bit            pending;
    int            lat;
    bus.core_done = 1'b0;
    bus.core_pix  = '0;
    pending  = 1'b0;
    lat      = 0;
    heldCoef = '0;
    forever begin
      @(negedge sys_clk);
      sRst   = bus.core_rst;
      sStart = bus.core_start;
      sCoef  = bus.core_coef;
      @(posedge sys_clk); #1;
      if (sRst) begin
        bus.core_done = 1'b0;
        pending = 1'b0;
      end else if (sStart) begin
        heldCoef = sCoef;
        pending  = 1'b1;
        lat      = (fixedLat != 0) ? fixedLat : int'($urandom_range(2, 30));
      end else if (pending && !noDone) begin
        if (lat == 0) begin
          bus.core_done = 1'b1;
          bus.core_pix  = pixOf(heldCoef);
          pending = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin
    bus.m_pix_ready = 1'b1;
    forever begin
      @(posedge sys_clk); #1;
      bus.m_pix_ready = stallAll ? 1'b0 : (randReady ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n && bus.m_pix_valid && bus.m_pix_ready) begin
      rxPix.push_back(bus.m_pix_data);
      rxLast.push_back(bus.m_pix_last);
    end
    if (sys_rst_n && bus.core_start) startPulses++;
  end

  task automatic applyStimulus(input logic [15:0] d, input logic l);
    int w;
    w = 0;
    bus.s_coef_valid = 1'b1;
    bus.s_coef_data  = d;
    bus.s_coef_last  = l;
    @(negedge sys_clk);
    while (!bus.s_coef_ready && w < 20000) begin
      @(negedge sys_clk);
      w++;
    end
    if (!bus.s_coef_ready) checkOutput("coefReadyWait", 64'(bus.s_coef_ready), 64'(1));
    @(posedge sys_clk); #1;
    bus.s_coef_valid = 1'b0;
    bus.s_coef_last  = 1'b0;
  endtask

  task automatic sendBlock(input bit ramp, input int lastPos, input bit expectOut);
    logic [1023:0] blk;
    logic [511:0]  p;
    logic [15:0]   c;
    for (int i = 0; i < 64; i++) begin
      c = ramp ? 16'(i) : 16'($urandom);
      blk[16*i +: 16] = c;
      applyStimulus(c, i == lastPos);
    end
    if (expectOut) begin
      p = pixOf(blk);
      for (int i = 0; i < 64; i++) expPix.push_back(p[8*i +: 8]);
      expBlk++;
    end
  endtask

  task automatic checkDelivered(input string tag);
    int w;
    int n;
    w = 0;
    while (rxPix.size() < expPix.size() && w < 30000) begin
      @(negedge sys_clk);
      w++;
    end
    @(negedge sys_clk);
    checkOutput({tag, "_pixCount"}, 64'(rxPix.size()), 64'(expPix.size()));
    n = (rxPix.size() < expPix.size()) ? rxPix.size() : expPix.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_pix%0d", tag, i), 64'(rxPix[i]), 64'(expPix[i]));
      checkOutput($sformatf("%s_last%0d", tag, i), 64'(rxLast[i]), 64'(i % 64 == 63));
    end
    rxPix.delete();
    rxLast.delete();
    expPix.delete();
    checkOutput({tag, "_blkCount"}, 64'(blk_count), 64'(16'(expBlk)));
  endtask

  initial begin
    int          w;
    logic        prevReady;
    bus.s_coef_valid = 1'b0;
    bus.s_coef_data  = '0;
    bus.s_coef_last  = 1'b0;

    // Reset values
    sys_rst_n = 1'b0;
    #12;
    checkOutput("rst_coreRst", 64'(bus.core_rst), 64'(1));
    checkOutput("rst_coreStart", 64'(bus.core_start), 64'(0));
    checkOutput("rst_pixValid", 64'(bus.m_pix_valid), 64'(0));
    checkOutput("rst_pixData", 64'(bus.m_pix_data), 64'(0));
    checkOutput("rst_pixLast", 64'(bus.m_pix_last), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_errLen", 64'(err_len), 64'(0));
    checkOutput("rst_errTmo", 64'(err_tmo), 64'(0));
    checkOutput("rst_blkCount", 64'(blk_count), 64'(0));
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    checkOutput("rst_coefReady", 64'(bus.s_coef_ready), 64'(1));
    @(posedge sys_clk); #1;

    // Single ramp block with start-pulse timing
    $display("[TB] single ramp block");
    sendBlock(1'b1, 63, 1'b1);
    @(negedge sys_clk);
    checkOutput("t1_busy", 64'(busy), 64'(1));
    checkOutput("t1_startT1", 64'(bus.core_start), 64'(0));
    @(negedge sys_clk);
    checkOutput("t1_startT2", 64'(bus.core_start), 64'(0));
    checkOutput("t1_coreRstT2", 64'(bus.core_rst), 64'(1));
    @(negedge sys_clk);
    checkOutput("t1_startT3", 64'(bus.core_start), 64'(1));
    checkOutput("t1_coreRstT3", 64'(bus.core_rst), 64'(0));
    @(negedge sys_clk);
    checkOutput("t1_startT4", 64'(bus.core_start), 64'(0));
    checkDelivered("t1");
    checkOutput("t1_startPulses", 64'(startPulses), 64'(1));
    checkOutput("t1_errLen", 64'(err_len), 64'(0));
    checkOutput("t1_idleData", 64'(bus.m_pix_data), 64'(0));
    checkOutput("t1_idleBusy", 64'(busy), 64'(0));
    @(posedge sys_clk); #1;

    // Back-to-back blocks with a slow core: both banks fill before the first capture
    $display("[TB] back-to-back blocks");
    fixedLat = 80;
    sendBlock(1'b0, 63, 1'b1);
    sendBlock(1'b0, 63, 1'b1);
    @(negedge sys_clk);
    checkOutput("t2_readyDropped", 64'(bus.s_coef_ready), 64'(0));
    w = 0;
    prevReady = bus.s_coef_ready;
    while (!bus.m_pix_valid && w < 1000) begin
      prevReady = bus.s_coef_ready;
      @(negedge sys_clk);
      w++;
    end
    fixedLat = 0;
    checkOutput("t2_validRose", 64'(bus.m_pix_valid), 64'(1));
    checkOutput("t2_readyLowInCapt", 64'(prevReady), 64'(0));
    checkOutput("t2_readyReRise", 64'(bus.s_coef_ready), 64'(1));
    @(posedge sys_clk); #1;
    sendBlock(1'b0, 63, 1'b1);
    checkDelivered("t2");
    @(posedge sys_clk); #1;

    // Long output stall with two further blocks queued behind the buffer
    $display("[TB] output backpressure");
    stallAll = 1'b1;
    @(posedge sys_clk); #1;
    sendBlock(1'b0, 63, 1'b1);
    sendBlock(1'b0, 63, 1'b1);
    sendBlock(1'b0, 63, 1'b1);
    for (int k = 0; k < 5; k++) begin
      repeat (1000) @(negedge sys_clk);
      checkOutput($sformatf("t3_stallValid%0d", k), 64'(bus.m_pix_valid), 64'(1));
      checkOutput($sformatf("t3_stallData%0d", k), 64'(bus.m_pix_data), 64'(expPix[0]));
    end
    checkOutput("t3_coefReady", 64'(bus.s_coef_ready), 64'(0));
    checkOutput("t3_coreRst", 64'(bus.core_rst), 64'(0));
    checkOutput("t3_busy", 64'(busy), 64'(1));
    checkOutput("t3_noRx", 64'(rxPix.size()), 64'(0));
    stallAll = 1'b0;
    checkDelivered("t3");
    @(posedge sys_clk); #1;

    // Framing error: last on beat 10 and missing on beat 63
    $display("[TB] framing error");
    randReady = 1'b1;
    sendBlock(1'b0, 10, 1'b1);
    checkOutput("t4_errLenSet", 64'(err_len), 64'(1));
    checkDelivered("t4");
    checkOutput("t4_errLenSticky", 64'(err_len), 64'(1));
    randReady = 1'b0;
    @(posedge sys_clk); #1;

    // Core never finishes: abandoned after TMO cycles in C_WAIT
    $display("[TB] core timeout");
    noDone = 1'b1;
    sendBlock(1'b0, 63, 1'b0);
    repeat (103) @(negedge sys_clk);
    checkOutput("t5_tmoNotYet", 64'(err_tmo), 64'(0));
    checkOutput("t5_busyWaiting", 64'(busy), 64'(1));
    @(negedge sys_clk);
    checkOutput("t5_tmoSet", 64'(err_tmo), 64'(1));
    checkOutput("t5_busyReleased", 64'(busy), 64'(0));
    checkOutput("t5_coefReady", 64'(bus.s_coef_ready), 64'(1));
    repeat (20) @(negedge sys_clk);
    checkOutput("t5_noPixels", 64'(rxPix.size()), 64'(0));
    noDone = 1'b0;
    @(posedge sys_clk); #1;
    sendBlock(1'b0, 63, 1'b1);
    checkDelivered("t5");
    checkOutput("t5_tmoSticky", 64'(err_tmo), 64'(1));
    @(posedge sys_clk); #1;

    // Asynchronous reset in the middle of the second block
    $display("[TB] mid-block reset");
    randReady = 1'b1;
    sendBlock(1'b0, 63, 1'b1);
    for (int i = 0; i < 30; i++) applyStimulus(16'($urandom), 1'b0);
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("t6_pixValid", 64'(bus.m_pix_valid), 64'(0));
    checkOutput("t6_coreRst", 64'(bus.core_rst), 64'(1));
    checkOutput("t6_busy", 64'(busy), 64'(0));
    checkOutput("t6_blkCount", 64'(blk_count), 64'(0));
    checkOutput("t6_errLen", 64'(err_len), 64'(0));
    checkOutput("t6_errTmo", 64'(err_tmo), 64'(0));
    repeat (2) @(posedge sys_clk);
    #4;
    sys_rst_n = 1'b1;
    rxPix.delete();
    rxLast.delete();
    expPix.delete();
    expBlk = 0;
    @(posedge sys_clk); #1;
    sendBlock(1'b0, 63, 1'b1);
    checkDelivered("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
